// File: rtl/sht40_rx_frame.sv
// SHT40 read-phase receiver: samples SDA on SCL rises, assembles the 6-byte frame and checks both CRC-8s.
// Optional fixed-point conversion stage (CONV state, *_Centi ports) enabled by defining SHT40_CONVERT_EN.
module sht40_rx_frame #(
    parameter logic [2:0] READ_STATE = 3'd5,
    parameter int         NBYTES     = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Scl_Data,
    input  logic               Sda_Data,
    input  logic [2:0]         Master_State_Out,
    output logic [15:0]        Temp_Raw,
    output logic [15:0]        Hum_Raw,
    output logic [1:0]         Crc_Err,
    output logic               Frame_Valid,
    output logic               Frame_Abort,
`ifdef SHT40_CONVERT_EN
    output logic signed [15:0] Temp_Centi,
    output logic [15:0]        Hum_Centi,
`endif
    output logic               Busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, CONV} state_t;

    state_t      state_q, state_d;
    logic        scl_meta_q, scl_sync_q, scl_prev_q;
    logic        sda_meta_q, sda_sync_q;
    logic [2:0]  ms_prev_q, ms_prev_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic [7:0]  crc_q, crc_d;
    logic [15:0] t_word_q, t_word_d, h_word_q, h_word_d;
    logic        t_err_q, t_err_d, h_err_q, h_err_d;
    logic [15:0] temp_raw_q, temp_raw_d, hum_raw_q, hum_raw_d;
    logic [1:0]  crc_err_q, crc_err_d;
    logic        frame_valid_q, frame_valid_d;
    logic        frame_abort_q, frame_abort_d;
    logic        busy_q, busy_d;

    logic        scl_rise, read_now, read_entry, last_rise, crc_fb, crc_byte;
    logic [7:0]  crc_next, rx_byte;

`ifdef SHT40_CONVERT_EN
    logic signed [15:0] temp_centi_q, temp_centi_d;
    logic [15:0]        hum_centi_q, hum_centi_d;
    logic [31:0]        t_prod, h_prod;
    logic signed [16:0] h_tmp;
`endif

    assign scl_rise   = scl_sync_q & ~scl_prev_q;
    assign read_now   = (Master_State_Out == READ_STATE);
    assign read_entry = read_now && (ms_prev_q != READ_STATE);
    assign last_rise  = scl_rise && (bit_cnt_q == 4'd8) && (byte_cnt_q == 3'(NBYTES - 1));
    assign crc_fb     = crc_q[7] ^ sda_sync_q;
    assign crc_next   = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h31 : 8'h00);
    assign rx_byte    = {shift_q, sda_sync_q};
    assign crc_byte   = (byte_cnt_q == 3'd2) || (byte_cnt_q == 3'd5);

    always_comb begin
        // NOTE: every _d starts from its _q (or a pulse default) so no path can infer a latch.
        state_d       = state_q;
        ms_prev_d     = Master_State_Out;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        shift_d       = shift_q;
        crc_d         = crc_q;
        t_word_d      = t_word_q;
        h_word_d      = h_word_q;
        t_err_d       = t_err_q;
        h_err_d       = h_err_q;
        temp_raw_d    = temp_raw_q;
        hum_raw_d     = hum_raw_q;
        crc_err_d     = crc_err_q;
        frame_valid_d = 1'b0;
        frame_abort_d = 1'b0;
`ifdef SHT40_CONVERT_EN
        temp_centi_d  = temp_centi_q;
        hum_centi_d   = hum_centi_q;
        t_prod        = 32'(temp_raw_q) * 32'd17500;
        h_prod        = 32'(hum_raw_q) * 32'd12500;
        h_tmp         = $signed({1'b0, h_prod[31:16]}) - 17'sd600;
`endif
        case (state_q)
            IDLE: begin
                if (read_entry) begin
                    state_d    = SHIFT;
                    bit_cnt_d  = 4'd0;
                    byte_cnt_d = 3'd0;
                    crc_d      = 8'hFF;
                end
            end
            SHIFT: begin
                // A completing rise wins over a simultaneous exit from the read state.
                if (last_rise) begin
                    state_d    = CHECK;
                    temp_raw_d = t_word_q;
                    hum_raw_d  = h_word_q;
                    crc_err_d  = {h_err_q, t_err_q};
`ifndef SHT40_CONVERT_EN
                    frame_valid_d = 1'b1;
`endif
                end else if (!read_now) begin
                    state_d       = IDLE;
                    frame_abort_d = 1'b1;
                end else if (scl_rise) begin
                    if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d  = 4'd0;
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        shift_d   = rx_byte[6:0];
                        if (crc_byte) begin
                            if (bit_cnt_q == 4'd7) begin
                                crc_d = 8'hFF;
                                if (byte_cnt_q == 3'd2) t_err_d = (rx_byte != crc_q);
                                else                    h_err_d = (rx_byte != crc_q);
                            end
                        end else begin
                            crc_d = crc_next;
                            if (bit_cnt_q == 4'd7) begin
                                case (byte_cnt_q)
                                    3'd0:    t_word_d[15:8] = rx_byte;
                                    3'd1:    t_word_d[7:0]  = rx_byte;
                                    3'd3:    h_word_d[15:8] = rx_byte;
                                    default: h_word_d[7:0]  = rx_byte;
                                endcase
                            end
                        end
                    end
                end
            end
            CHECK: begin
`ifdef SHT40_CONVERT_EN
                state_d       = CONV;
                frame_valid_d = 1'b1;
                temp_centi_d  = $signed(t_prod[31:16] - 16'd4500);
                if (h_tmp < 0)                 hum_centi_d = 16'd0;
                else if (h_tmp > 17'sd10000)   hum_centi_d = 16'd10000;
                else                           hum_centi_d = h_tmp[15:0];
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: bus lines reset to their idle-high level so leaving reset never fakes an SCL rise.
            scl_meta_q    <= 1'b1;
            scl_sync_q    <= 1'b1;
            scl_prev_q    <= 1'b1;
            sda_meta_q    <= 1'b1;
            sda_sync_q    <= 1'b1;
            state_q       <= IDLE;
            ms_prev_q     <= 3'd0;
            bit_cnt_q     <= 4'd0;
            byte_cnt_q    <= 3'd0;
            shift_q       <= 7'd0;
            crc_q         <= 8'hFF;
            t_word_q      <= 16'd0;
            h_word_q      <= 16'd0;
            t_err_q       <= 1'b0;
            h_err_q       <= 1'b0;
            temp_raw_q    <= 16'd0;
            hum_raw_q     <= 16'd0;
            crc_err_q     <= 2'b00;
            frame_valid_q <= 1'b0;
            frame_abort_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef SHT40_CONVERT_EN
            temp_centi_q  <= 16'sd0;
            hum_centi_q   <= 16'd0;
`endif
        end else begin
            scl_meta_q    <= Scl_Data;
            scl_sync_q    <= scl_meta_q;
            scl_prev_q    <= scl_sync_q;
            sda_meta_q    <= Sda_Data;
            sda_sync_q    <= sda_meta_q;
            state_q       <= state_d;
            ms_prev_q     <= ms_prev_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            shift_q       <= shift_d;
            crc_q         <= crc_d;
            t_word_q      <= t_word_d;
            h_word_q      <= h_word_d;
            t_err_q       <= t_err_d;
            h_err_q       <= h_err_d;
            temp_raw_q    <= temp_raw_d;
            hum_raw_q     <= hum_raw_d;
            crc_err_q     <= crc_err_d;
            frame_valid_q <= frame_valid_d;
            frame_abort_q <= frame_abort_d;
            busy_q        <= busy_d;
`ifdef SHT40_CONVERT_EN
            temp_centi_q  <= temp_centi_d;
            hum_centi_q   <= hum_centi_d;
`endif
        end
    end

    assign Temp_Raw    = temp_raw_q;
    assign Hum_Raw     = hum_raw_q;
    assign Crc_Err     = crc_err_q;
    assign Frame_Valid = frame_valid_q;
    assign Frame_Abort = frame_abort_q;
    assign Busy        = busy_q;
`ifdef SHT40_CONVERT_EN
    assign Temp_Centi  = temp_centi_q;
    assign Hum_Centi   = hum_centi_q;
`endif

endmodule

// File: tb/tb_sht40_rx_frame.sv
// Bench for sht40_rx_frame: table of frames driven bit-serially, scoreboard queue checked on Frame_Valid,
// plus hand-written abort, simultaneous-exit, trailing-rise and mid-frame reset sequences.
module tb_sht40_rx_frame;

    typedef struct packed {
        logic [47:0] bytes;
        logic [15:0] t;
        logic [15:0] h;
        logic [1:0]  e;
        logic [15:0] tc;
        logic [15:0] hc;
    } vec_t;

`ifdef SHT40_CONVERT_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam int NVEC = 6;

    logic        clk = 1'b0;
    logic        rst, scl, sda;
    logic [2:0]  mso;
    logic [15:0] Temp_Raw, Hum_Raw;
    logic [1:0]  Crc_Err;
    logic        Frame_Valid, Frame_Abort, Busy;
`ifdef SHT40_CONVERT_EN
    logic signed [15:0] Temp_Centi;
    logic [15:0]        Hum_Centi;
`endif

    int   checks = 0, failures = 0;
    int   cyc = 0, rise_cyc = 0, n_valid = 0, n_abort = 0, n_push = 0;
    vec_t sb[$];
    vec_t tbl[NVEC];
    vec_t mon_e;

    sht40_rx_frame dut (
        .clk(clk), .rst(rst), .Scl_Data(scl), .Sda_Data(sda), .Master_State_Out(mso),
        .Temp_Raw(Temp_Raw), .Hum_Raw(Hum_Raw), .Crc_Err(Crc_Err),
        .Frame_Valid(Frame_Valid), .Frame_Abort(Frame_Abort),
`ifdef SHT40_CONVERT_EN
        .Temp_Centi(Temp_Centi), .Hum_Centi(Hum_Centi),
`endif
        .Busy(Busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && Frame_Valid) begin
            n_valid++;
            if (sb.size() == 0) begin
                check("valid_without_frame", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("temp_raw", Temp_Raw, mon_e.t);
                check("hum_raw", Hum_Raw, mon_e.h);
                check("crc_err", Crc_Err, mon_e.e);
                check("latency", cyc - rise_cyc, LAT);
`ifdef SHT40_CONVERT_EN
                check("temp_centi", 32'($unsigned(Temp_Centi)), mon_e.tc);
                check("hum_centi", Hum_Centi, mon_e.hc);
`endif
            end
        end
        if (!rst && Frame_Abort) n_abort++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives nrises SCL bits of frame v; the 54th rise pushes v to the scoreboard.
    task automatic send_frame(input vec_t v, input int nrises, input bit exit_on_last);
        int   by, bi;
        logic b;
        for (int i = 0; i < nrises; i++) begin
            by = i / 9;
            bi = i % 9;
            if (bi == 8) b = (by == 5);
            else         b = v.bytes[47 - 8 * by - bi];
            scl = 1'b0;
            sda = b;
            tick(3);
            if (i == 53) begin
                sb.push_back(v);
                n_push++;
                rise_cyc = cyc;
            end
            scl = 1'b1;
            if (i == 53 && exit_on_last) begin
                tick(2);
                mso = 3'd0;
                tick(1);
            end else begin
                tick(3);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) tick(1);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic enter_read();
        mso = 3'd5;
        tick(2);
    endtask

    task automatic leave_read();
        mso = 3'd0;
        tick(3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_temp"}, Temp_Raw, 16'd0);
        check({tag, "_hum"}, Hum_Raw, 16'd0);
        check({tag, "_crc"}, Crc_Err, 2'b00);
        check({tag, "_valid"}, Frame_Valid, 1'b0);
        check({tag, "_abort"}, Frame_Abort, 1'b0);
        check({tag, "_busy"}, Busy, 1'b0);
    endtask

    initial begin
        int na, nv;
        tbl[0] = '{48'hBEEF92_BEEF92, 16'hBEEF, 16'hBEEF, 2'b00, 16'd8552,  16'd8722};
        tbl[1] = '{48'hBEEF92_000080, 16'hBEEF, 16'h0000, 2'b10, 16'd8552,  16'd0};
        tbl[2] = '{48'h000081_000081, 16'h0000, 16'h0000, 2'b00, 16'hEE6C,  16'd0};
        tbl[3] = '{48'hBEEF00_BEEF92, 16'hBEEF, 16'hBEEF, 2'b01, 16'd8552,  16'd8722};
        tbl[4] = '{48'h000000_BEEF00, 16'h0000, 16'hBEEF, 2'b11, 16'hEE6C,  16'd8722};
        tbl[5] = '{48'hFFFFAC_FFFFAC, 16'hFFFF, 16'hFFFF, 2'b00, 16'd12999, 16'd10000};

        rst = 1'b1; mso = 3'd0; scl = 1'b1; sda = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        check_reset_outputs("reset");

        for (int k = 0; k < NVEC; k++) begin
            enter_read();
            check("busy_in_shift", Busy, 1'b1);
            send_frame(tbl[k], 54, 1'b0);
            drain();
            check("busy_after_frame", Busy, 1'b0);
            leave_read();
        end

        // Trailing rises while still in the read state must not start a new frame.
        enter_read();
        send_frame(tbl[0], 54, 1'b0);
        drain();
        nv = n_valid;
        send_frame(tbl[1], 9, 1'b0);
        tick(5);
        check("no_rearm_valids", n_valid, nv);
        check("no_rearm_busy", Busy, 1'b0);
        leave_read();

        // Abort after 20 rises: one abort pulse, words keep tbl[0] values.
        na = n_abort;
        nv = n_valid;
        enter_read();
        send_frame(tbl[2], 20, 1'b0);
        mso = 3'd0;
        tick(6);
        check("abort_pulses", n_abort, na + 1);
        check("abort_no_valid", n_valid, nv);
        check("abort_temp_held", Temp_Raw, tbl[0].t);
        check("abort_hum_held", Hum_Raw, tbl[0].h);
        check("abort_busy", Busy, 1'b0);

        // 54th rise and read-state exit on the same cycle: frame completes, no abort.
        na = n_abort;
        enter_read();
        send_frame(tbl[1], 54, 1'b1);
        drain();
        check("simul_no_abort", n_abort, na);
        tick(3);

        // Reset held two cycles mid-frame, then a normal frame.
        enter_read();
        send_frame(tbl[3], 30, 1'b0);
        rst = 1'b1;
        tick(2);
        check_reset_outputs("midreset");
        rst = 1'b0;
        mso = 3'd0;
        scl = 1'b1;
        tick(3);
        enter_read();
        send_frame(tbl[0], 54, 1'b0);
        drain();
        leave_read();

        check("total_valids", n_valid, n_push);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
